// File: rtl/gx400_video_sram_ctrl.sv
// ============================================================================
// gx400_video_sram_ctrl
// CPU / video-fetch arbiter driving one single-port synchronous video SRAM.
// Optional build macro: GX400_VRAM_VID_PRIORITY_EN (video wins all contention).
// Revision: 1.0
// ============================================================================
`default_nettype none

module gx400_video_sram_ctrl #(
    parameter int DW = 8,
    parameter int AW = 10
) (
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    input  logic          i_CPU_CS_n,
    input  logic          i_CPU_RW,
    input  logic [AW-1:0] i_CPU_ADDR,
    input  logic [DW-1:0] i_CPU_DIN,
    output logic [DW-1:0] o_CPU_DOUT,
    output logic          o_CPU_DTACK_n,
    input  logic          i_VID_REQ,
    input  logic [AW-1:0] i_VID_ADDR,
    output logic [DW-1:0] o_VID_DATA,
    output logic          o_VID_DVAL,
    output logic          o_VID_OVF,
    output logic [AW-1:0] o_RAM_ADDR,
    output logic [DW-1:0] o_RAM_DIN,
    output logic          o_RAM_WR_n,
    output logic          o_RAM_RD_n,
    input  logic [DW-1:0] i_RAM_DOUT
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_WR_DONE  = 3'd4,
        ST_ACK      = 3'd5
    } cpu_state_t;

    cpu_state_t    state;
    cpu_state_t    state_nx;
    logic          cs_prev;
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic          vid_issued;
    logic          vid_pend;

    logic          vid_cand;
    logic          cpu_cand;
    logic          vid_wins_tie;
    logic          grant_vid;
    logic          grant_cpu;
    logic [AW-1:0] vid_addr_sel;

    // A buffered request is always older than a fresh one, so it goes first.
    assign vid_cand     = buf_valid | i_VID_REQ;
    assign vid_addr_sel = buf_valid ? buf_addr : i_VID_ADDR;
    assign cpu_cand     = (state == ST_REQ);
    assign grant_vid    = vid_cand & (~cpu_cand | vid_wins_tie);
    assign grant_cpu    = cpu_cand & ~grant_vid;

`ifdef GX400_VRAM_VID_PRIORITY_EN
    assign vid_wins_tie = 1'b1;
`else
    logic fair;

    // Fairness bit flips only when both sides want the same slot.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            fair <= 1'b0;
        end else if (vid_cand && cpu_cand) begin
            fair <= ~fair;
        end
    end

    assign vid_wins_tie = ~fair;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (cs_prev && !i_CPU_CS_n) state_nx = ST_REQ;
            ST_REQ:      if (grant_cpu) state_nx = i_CPU_RW ? ST_RD_ISSUE : ST_WR_DONE;
            ST_RD_ISSUE: state_nx = ST_RD_WAIT;
            ST_RD_WAIT:  state_nx = ST_ACK;
            ST_WR_DONE:  state_nx = ST_ACK;
            ST_ACK:      if (i_CPU_CS_n) state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state         <= ST_IDLE;
            cs_prev       <= 1'b1;
            buf_valid     <= 1'b0;
            buf_addr      <= '0;
            vid_issued    <= 1'b0;
            vid_pend      <= 1'b0;
            o_CPU_DOUT    <= '0;
            o_CPU_DTACK_n <= 1'b1;
            o_VID_DATA    <= '0;
            o_VID_DVAL    <= 1'b0;
            o_VID_OVF     <= 1'b0;
            o_RAM_ADDR    <= '0;
            o_RAM_DIN     <= '0;
            o_RAM_WR_n    <= 1'b1;
            o_RAM_RD_n    <= 1'b1;
        end else begin
            state         <= state_nx;
            cs_prev       <= i_CPU_CS_n;
            o_CPU_DTACK_n <= (state != ST_ACK);

            o_RAM_RD_n <= ~(grant_vid | (grant_cpu & i_CPU_RW));
            o_RAM_WR_n <= ~(grant_cpu & ~i_CPU_RW);
            if (grant_vid) begin
                o_RAM_ADDR <= vid_addr_sel;
            end else if (grant_cpu) begin
                o_RAM_ADDR <= i_CPU_ADDR;
            end
            if (grant_cpu && !i_CPU_RW) begin
                o_RAM_DIN <= i_CPU_DIN;
            end

            // Buffer refills from a fresh request whenever the slot cannot take it.
            if (grant_vid) begin
                buf_valid <= buf_valid & i_VID_REQ;
                if (buf_valid && i_VID_REQ) buf_addr <= i_VID_ADDR;
            end else begin
                buf_valid <= buf_valid | i_VID_REQ;
                if (!buf_valid && i_VID_REQ) buf_addr <= i_VID_ADDR;
            end
            o_VID_OVF <= i_VID_REQ & buf_valid & ~grant_vid;

            // SRAM data is valid the cycle after the strobe; capture at its end.
            vid_issued <= grant_vid;
            vid_pend   <= vid_issued;
            o_VID_DVAL <= vid_pend;
            if (vid_pend) begin
                o_VID_DATA <= i_RAM_DOUT;
            end
            if (state == ST_RD_WAIT) begin
                o_CPU_DOUT <= i_RAM_DOUT;
            end
        end
    end

endmodule

`default_nettype wire
